// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store, one access in flight.
// Latency: ready pulses 2 + memory-latency cycles after the grant cycle; ram_en is the first BUSY cycle.
// Backpressure: requests are levels held until their ready pulse; stall_* stay high while waiting.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STREAK_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    output logic                  stall_if,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  stall_mem,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_valid,
    output logic                  err_timeout
);
    localparam int SW = $clog2(STREAK_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_TOP   = SW'(STREAK_MAX);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic [TW-1:0] tmo_cnt;
    logic          squash;
    logic          if_req_eff;
    logic          mem_req_eff;
    logic          grant_mem;
    logic          grant_if;
    logic          if_squashed;

    // A request whose ready pulse is high this cycle has already been served.
    assign if_req_eff  = if_req & ~if_ready;
    assign mem_req_eff = mem_req & ~mem_ready;
    assign grant_mem   = (state == IDLE) && mem_req_eff && (!if_req_eff || streak != STREAK_TOP);
    assign grant_if    = (state == IDLE) && if_req_eff && !grant_mem;
    assign if_squashed = squash | flush;
    assign stall_if    = if_req & ~if_ready;
    assign stall_mem   = mem_req & ~mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            streak      <= '0;
            tmo_cnt     <= '0;
            squash      <= 1'b0;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            if_rdata    <= '0;
            if_ready    <= 1'b0;
            mem_rdata   <= '0;
            mem_ready   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ram_en    <= 1'b0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;

            if (!if_req_eff || grant_if) begin
                streak <= '0;
            end else if (grant_mem && streak != STREAK_TOP) begin
                streak <= streak + SW'(1);
            end

            case (state)
                IDLE: begin
                    squash <= 1'b0;
                    if (grant_mem) begin
                        state     <= BUSY_MEM;
                        ram_en    <= 1'b1;
                        ram_we    <= mem_we;
                        ram_addr  <= mem_addr;
                        ram_wdata <= mem_wdata;
                        tmo_cnt   <= '0;
                    end else if (grant_if) begin
                        state    <= BUSY_IF;
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_addr <= if_addr;
                        tmo_cnt  <= '0;
                        squash   <= flush;
                    end
                end
                BUSY_IF: begin
                    if (ram_valid) begin
                        state <= IDLE;
                        if (!if_squashed) begin
                            if_rdata <= ram_rdata;
                            if_ready <= 1'b1;
                        end
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                        if (!if_squashed) begin
                            if_rdata <= '0;
                            if_ready <= 1'b1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                        squash  <= if_squashed;
                    end
                end
                BUSY_MEM: begin
                    if (ram_valid) begin
                        state     <= IDLE;
                        mem_rdata <= ram_rdata;
                        mem_ready <= 1'b1;
                    end else if (tmo_cnt == TIMEOUT_LAST) begin
                        state       <= IDLE;
                        err_timeout <= 1'b1;
                        mem_rdata   <= '0;
                        mem_ready   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- One transaction is outstanding at a time. MEM has priority, with a streak limit that prevents IF starvation.
- Squashes fetches made stale by a branch or jump, detects memory timeouts, and generates per-stage stall signals for the pipeline.

Parameters:
- ADDR_WIDTH, 32, width of all addresses (matches PC_WIDTH).
- DATA_WIDTH, 32, width of memory data (matches INSTRUCTION_WIDTH/GPR_WIDTH).
- STREAK_MAX, 4, maximum consecutive MEM grants while if_req is pending.
- TIMEOUT, 255, number of BUSY cycles without ram_valid before the transaction is aborted.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req=1.
- flush  in  1  branch_taken|is_jump pulse; the current fetch is stale.
- if_rdata  out  DATA_WIDTH  fetched instruction; valid when if_ready=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- stall_if  out  1  if_req & ~if_ready (combinational).
- mem_req  in  1  load/store request; level, held until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_WIDTH  load/store address.
- mem_wdata  in  DATA_WIDTH  store data.
- mem_rdata  out  DATA_WIDTH  load data; valid when mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- stall_mem  out  1  mem_req & ~mem_ready (combinational).
- ram_en  out  1  one-cycle command strobe to memory.
- ram_we  out  1  write enable, qualified by ram_en.
- ram_addr  out  ADDR_WIDTH  registered command address.
- ram_wdata  out  DATA_WIDTH  registered write data.
- ram_rdata  in  DATA_WIDTH  memory read data.
- ram_valid  in  1  memory completion, for both reads and writes.
- err_timeout  out  1  sticky flag; cleared only by reset.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: state IDLE; ram_en, ram_we, if_ready, mem_ready, err_timeout = 0; ram_addr, ram_wdata, if_rdata, mem_rdata = 0; streak counter, timeout counter and squash flag = 0.
- Reset mid-transaction: the transaction is abandoned. A late ram_valid arriving in IDLE is ignored.
- FSM states: IDLE, BUSY_IF, BUSY_MEM.
- Request consumption: in any cycle where x_ready=1, x_req is treated as 0. This prevents re-granting a request that has just completed.
- IDLE grant rules:
  - mem_req only: grant MEM.
  - if_req only: grant IF.
  - Both requesting: grant MEM, unless streak == STREAK_MAX, in which case grant IF.
  - On any grant: register the address, data and we into ram_*; assert ram_en=1 for exactly one cycle (the first BUSY cycle); ram_we = mem_we for MEM grants and 0 for IF grants.
- Streak counter:
  - Increments on each MEM grant made while if_req=1, saturating at STREAK_MAX.
  - Clears on an IF grant, or in any cycle where if_req=0.
- BUSY_x completion:
  - ram_valid is sampled in every BUSY cycle, including the ram_en cycle.
  - When ram_valid=1: x_rdata <= ram_rdata (MEM stores also capture ram_rdata, value unspecified); x_ready pulses high next cycle for 1 cycle; state goes to IDLE.
  - Best-case latency from request to ready: 2 cycles, when ram_valid is returned in the ram_en cycle. In general: 2 + memory latency.
- Back-to-back: the cycle in which the ready pulse is high is an IDLE cycle and may grant the other requester. Issue throughput is one transaction per 2 + L cycles.
- Flush:
  - In BUSY_IF, or in the cycle an IF grant is made: set squash. The memory transaction still completes; on ram_valid, if_ready is suppressed and if_rdata is left unchanged. squash clears on return to IDLE.
  - flush in the same cycle as ram_valid in BUSY_IF: suppress the ready pulse.
  - flush in IDLE with no IF grant, or in BUSY_MEM: no effect.
  - stall_if stays high until the re-fetch at the new PC completes.
- Timeout:
  - The timeout counter clears on each grant and increments in each BUSY cycle with ram_valid=0.
  - On reaching TIMEOUT: set err_timeout; pulse x_ready with x_rdata = 0 (no pulse if squashed); go to IDLE.
- ram_valid in IDLE: ignored.

Test Plan:
- Single fetch, memory returning data with L=3: if_req=1, if_addr=0x10, ram_rdata=0x8C220004 -> ram_en one cycle with ram_addr=0x10, ram_we=0; if_ready at cycle 5; if_rdata=0x8C220004; stall_if high for cycles 0-4.
- Simultaneous requests, L=0: if_req=1, mem_req=1 with mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF -> MEM granted first (ram_we=1, ram_wdata=0xDEADBEEF); mem_ready pulse; IF granted in the same cycle; if_ready 2 cycles later.
- Starvation: mem_req held high, re-raised every cycle, with if_req=1, L=0 -> 4 MEM grants, then 1 IF grant, then the streak restarts at 0.
- Flush: flush at cycle 2 of an IF fetch to 0x40 with L=3 -> ram_valid consumed, no if_ready, if_rdata unchanged; re-issued fetch to 0x80 completes normally.
- Timeout: IF grant with ram_valid never asserted, TIMEOUT=255 -> err_timeout=1 after 255 BUSY cycles; if_ready pulse with if_rdata=0; next request granted normally; err_timeout stays 1.
- Reset mid-BUSY_MEM: rst=0 for 1 cycle, async -> all outputs at reset values immediately; state IDLE; subsequent ram_valid ignored; no mem_ready pulse.
